// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop input synchronizer, mid-bit oversampling FSM, byte/framing strobes.
// Optional even-parity bit between data and stop is enabled by defining RX_PARITY_EN.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_input,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       framing_error,
`ifdef RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
`ifdef RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  logic rx;
  logic half_done;
  logic bit_done;

  assign rx        = sync_q[1];
  assign half_done = (cnt_q == HALF_LAST);
  assign bit_done  = (cnt_q == FULL_LAST);

  // State register and all datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], serial_input};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!rx) state_d = S_START;
      S_START: if (half_done) state_d = rx ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_done && idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done) state_d = rx ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, shift register and strobe next values
  always_comb begin
    cnt_d   = (bit_done) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (state_q == S_DATA && bit_done) begin
      shift_d[idx_q] = rx;
      idx_d          = idx_q + 3'd1;
    end
`ifdef RX_PARITY_EN
    if (state_q == S_PARITY && bit_done) par_d = rx;
`endif
    if (state_q == S_STOP && bit_done) begin
      if (rx) begin
        valid_d = 1'b1;
        byte_d  = shift_q;
      end else begin
        ferr_d = 1'b1;
      end
`ifdef RX_PARITY_EN
      perr_d = (^shift_q) ^ par_q;
`endif
    end
    // Every state entry starts a fresh bit period and bit index
    if (state_d != state_q) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  assign byte_out      = byte_q;
  assign byte_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != S_IDLE);
`ifdef RX_PARITY_EN
  assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, corner sequences, randomized frames vs model.
module tb_uart_receiver;

  localparam int N = 16;
`ifdef RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // pin change -> 2 sync cycles -> IDLE detect -> START/DATA/STOP -> registered pulse
  localparam int LAT = 3 + N / 2 + (9 + PBITS) * N;
  localparam int FRAME = (10 + PBITS) * N;

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_input;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       framing_error;
  logic       busy;
  logic       perr_w;

  uart_receiver #(.CLKS_PER_BIT(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_input (serial_input),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .framing_error(framing_error),
`ifdef RX_PARITY_EN
    .parity_error (perr_w),
`endif
    .busy         (busy)
  );
`ifndef RX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got_q[$];
  int         pulse_t[$];
  int         ferr_n, perr_n, both_n, orphan_n;
  bit         busy_seen;

  initial forever begin
    @(negedge clock);
    if (byte_valid) begin
      got_q.push_back(byte_out);
      pulse_t.push_back(cyc);
    end
    if (framing_error) begin
      ferr_n++;
      pulse_t.push_back(cyc);
    end
    if (byte_valid && framing_error) both_n++;
    if (perr_w) begin
      perr_n++;
      if (!(byte_valid || framing_error)) orphan_n++;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic clear_mon();
    got_q.delete();
    pulse_t.delete();
    ferr_n = 0; perr_n = 0; both_n = 0; orphan_n = 0;
    busy_seen = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    serial_input = b;
    tick(n);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop bit (or a held-low line of 'hold' cycles)
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input logic pbit, input int hold);
    $display("frame data=0x%02h stop_ok=%0d pbit=%0d t=%0d", d, stop_ok, pbit, cyc);
    drive_bit(1'b0, N);
    for (int i = 0; i < 8; i++) drive_bit(d[i], N);
`ifdef RX_PARITY_EN
    drive_bit(pbit, N);
`endif
    if (stop_ok) drive_bit(1'b1, N);
    else begin
      drive_bit(1'b0, hold);
      drive_bit(1'b1, N);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d, input bit ok);
    return (^d) ^ !ok;
  endfunction

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
    logic [7:0] exp_out;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    int exp_ferr, exp_perr, t0, nmin;

    vecs.push_back('{8'hA5, 1'b1, 1'b1, 8'hA5, 1, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b1, 8'hA5, 0, 1, 0});
    vecs.push_back('{8'h5A, 1'b1, 1'b1, 8'h5A, 1, 0, 0});
    vecs.push_back('{8'hC3, 1'b1, 1'b1, 8'hC3, 1, 0, 0});
`ifdef RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 1, 0, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1, 0, 1});
`endif

    reset = 1'b1;
    serial_input = 1'b1;
    clear_mon();
    tick(3);
    check("reset_byte_out", byte_out, 0);
    check("reset_byte_valid", byte_valid, 0);
    check("reset_framing_error", framing_error, 0);
    check("reset_busy", busy, 0);
    check("reset_parity_error", perr_w, 0);
    reset = 1'b0;
    tick(5);

    // Directed frame table
    foreach (vecs[v]) begin
      clear_mon();
      t0 = cyc;
      send_frame(vecs[v].data, vecs[v].stop_ok, even_par(vecs[v].data, vecs[v].par_ok), 40);
      tick(20);
      check($sformatf("vec%0d_valid_count", v), got_q.size(), vecs[v].exp_valid);
      if (vecs[v].exp_valid > 0)
        check($sformatf("vec%0d_got_byte", v), (got_q.size() > 0) ? int'(got_q[0]) : -1, vecs[v].data);
      check($sformatf("vec%0d_byte_out", v), byte_out, vecs[v].exp_out);
      check($sformatf("vec%0d_ferr_count", v), ferr_n, vecs[v].exp_ferr);
      check($sformatf("vec%0d_perr_count", v), perr_n, vecs[v].exp_perr);
      check($sformatf("vec%0d_latency", v), (pulse_t.size() > 0) ? pulse_t[0] - t0 : -1, LAT);
      check($sformatf("vec%0d_busy_after", v), busy, 0);
      check($sformatf("vec%0d_both_pulses", v), both_n, 0);
    end

    // Glitch: 4 low cycles must be rejected at the mid-start sample
    clear_mon();
    $display("glitch low 4 cycles t=%0d", cyc);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_no_valid", got_q.size(), 0);
    check("glitch_no_ferr", ferr_n, 0);
    check("glitch_busy_after", busy, 0);
    check("glitch_byte_out", byte_out, vecs[vecs.size()-1].exp_out);

    // Back-to-back frames with no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1, even_par(8'h00, 1'b1), 0);
    send_frame(8'hFF, 1'b1, even_par(8'hFF, 1'b1), 0);
    tick(20);
    check("b2b_valid_count", got_q.size(), 2);
    check("b2b_first", (got_q.size() > 0) ? int'(got_q[0]) : -1, 8'h00);
    check("b2b_second", (got_q.size() > 1) ? int'(got_q[1]) : -1, 8'hFF);
    check("b2b_spacing", (pulse_t.size() > 1) ? pulse_t[1] - pulse_t[0] : -1, FRAME);
    check("b2b_byte_out", byte_out, 8'hFF);

    // Reset pulse during data bit 4; remaining bits are all high so nothing retriggers
    clear_mon();
    fork
      send_frame(8'hF7, 1'b1, even_par(8'hF7, 1'b1), 0);
      begin
        tick(5 * N + 8);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_byte_out", byte_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", byte_valid, 0);
        check("midrst_ferr", framing_error, 0);
      end
    join
    tick(20);
    check("midrst_no_valid", got_q.size(), 0);
    check("midrst_no_ferr", ferr_n, 0);
    send_frame(8'h81, 1'b1, even_par(8'h81, 1'b1), 0);
    tick(20);
    check("after_rst_count", got_q.size(), 1);
    check("after_rst_byte", byte_out, 8'h81);

    // Randomized frames against the frame-level model
    clear_mon();
    exp_q.delete();
    exp_ferr = 0;
    exp_perr = 0;
    last_good = 8'h81;
    for (int f = 0; f < 24; f++) begin
      logic [7:0] d;
      bit s_ok, p_ok;
      int gap;
      d    = 8'($urandom);
      s_ok = ($urandom_range(0, 7) != 0);
      p_ok = ($urandom_range(0, 5) != 0);
      gap  = $urandom_range(0, 12);
      send_frame(d, s_ok, even_par(d, p_ok), N + $urandom_range(0, 24));
      if (gap > 0) drive_bit(1'b1, gap);
      if (s_ok) begin
        exp_q.push_back(d);
        last_good = d;
      end else exp_ferr++;
      if (PBITS == 1 && !p_ok) exp_perr++;
    end
    tick(30);
    check("rand_valid_count", got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++)
      check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
    check("rand_ferr_count", ferr_n, exp_ferr);
    check("rand_perr_count", perr_n, exp_perr);
    check("rand_perr_orphan", orphan_n, 0);
    check("rand_both_pulses", both_n, 0);
    check("rand_byte_out", byte_out, last_good);
    check("rand_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive half of the miniUART, the counterpart of the UART transmitter. It samples an asynchronous 8N1 line (start bit, 8 data bits LSB first, stop bit) with a per-bit clock-count oversampler. It presents each received byte on a parallel port with a one-cycle valid strobe, and flags framing errors. It sits between the serial input pin and the byte consumer, such as a loopback path or a future FIFO.

## Interface

- CLKS_PER_BIT, default 16: clock cycles per serial bit. Must be an even integer ≥ 4.
- clock  input  1  single system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_input  input  1  asynchronous serial line; idles high.
- byte_out  output  8  last correctly framed byte. Reset value 0x00.
- byte_valid  output  1  one-cycle pulse when byte_out is updated. Reset value 0.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low. Reset value 0.
- busy  output  1  high in every state except IDLE. Reset value 0.
- parity_error  output  1  present only with RX_PARITY_EN; one-cycle pulse. Reset value 0.

## Operation

- serial_input passes through a 2-flop synchronizer. That register chain resets to 1. All decisions use the synchronized signal `rx`.
- Bit-period counter width: clog2(CLKS_PER_BIT). Bit index: 3 bits. Both are cleared on every state entry.
- States:
  - IDLE: on `rx`==0, go to START.
  - START: after CLKS_PER_BIT/2 cycles in START, sample `rx` at mid-bit. If 0, go to DATA. If 1, treat the low level as a glitch and return to IDLE with no output pulse.
  - DATA: sample `rx` every CLKS_PER_BIT cycles into shift register bit [index], LSB first. After index 7 is sampled, go to STOP (or PARITY with the macro).
  - STOP: sample `rx` after CLKS_PER_BIT cycles.
    - If 1: load byte_out from the shift register, pulse byte_valid, and go to IDLE.
    - If 0: pulse framing_error, leave byte_out unchanged, and go to BREAK.
  - BREAK: wait until `rx`==1, then go to IDLE. This prevents a held-low line from retriggering reception.
- Output pulses are registered and last exactly one cycle. byte_valid and framing_error are never high in the same cycle.
- Reset in any state: state returns to IDLE, counters and shift register clear, and all outputs take their reset values on the next edge. A partially received frame is discarded.
- A falling edge that arrives while busy is ignored. Resynchronization happens only from IDLE.

## Timing

- Latency from the first `rx`==0 in IDLE to the STOP sample: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles. Add CLKS_PER_BIT cycles with parity.
- The byte_valid or framing_error pulse is asserted on the clock edge immediately following the STOP sample cycle.
- The pin-to-`rx` delay adds 2 cycles.
- After a good stop bit the receiver is in IDLE and can detect a new start edge from the next cycle. A back-to-back frame whose start bit begins at the end of the stop bit is received without loss.
- byte_out holds its value until the next valid frame or reset.

## Configuration

- RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP, one bit period long. Parity is even: the XOR of the 8 data bits and the parity bit must equal 0.
  - A mismatch pulses parity_error on the same edge as the byte_valid or framing_error pulse. The byte is still delivered if framing is correct.
  - The parity_error port exists.
- RX_PARITY_EN undefined: the frame is 8N1, with no PARITY state and no parity_error port.

## Test plan

All scenarios use CLKS_PER_BIT=16.

- Frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> exactly one byte_valid pulse, byte_out=0xA5, framing_error stays 0, busy low afterwards.
- Line low for 4 cycles, then high -> busy pulses high, then returns to IDLE; no byte_valid and no framing_error pulse.
- Frame 0x3C with stop bit 0, line held low for 40 cycles, then high -> one framing_error pulse and no further pulses. byte_out keeps its prior value, for example 0xA5. A following 0x5A frame is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two byte_valid pulses 160 cycles apart, with byte_out 0x00 then 0xFF.
- reset asserted for 1 cycle during data bit 4 of a frame -> all outputs 0 on the next edge and no pulse for that frame. The next full frame, 0x81, is received.
- With RX_PARITY_EN: 0x07 with parity bit 1 -> byte_valid and no parity_error. 0x07 with parity bit 0 -> byte_valid plus a parity_error pulse on the same edge.
